// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - stepped-chirp phase-increment sequencer feeding the NCO core (optional macro NCO_SWEEP_LOOP_EN adds loop_en)
module nco_sweep_ctrl #(
    parameter int APR     = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               tri_mode,
    input  logic [APR-1:0]     f_start,
    input  logic [APR-1:0]     f_stop,
    input  logic [APR-1:0]     f_step,
    input  logic [DWELL_W-1:0] dwell,
`ifdef NCO_SWEEP_LOOP_EN
    input  logic               loop_en,
`endif
    output logic [APR-1:0]     phi_inc_o,
    output logic               freq_upd,
    output logic               busy,
    output logic               sweep_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN_FWD = 2'd1,
        S_RUN_REV = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t             r_state;
    logic [APR-1:0]     r_start;
    logic [APR-1:0]     r_stop;
    logic [APR-1:0]     r_step;
    logic [DWELL_W-1:0] r_dwell_m1;
    logic               r_tri;
    logic               r_dir_up;
    logic               r_degen;
    logic               r_loop;
    logic [DWELL_W-1:0] r_cnt;
    logic [APR-1:0]     r_phi;
    logic               r_upd;
    logic               r_busy;
    logic               r_done;

    logic [DWELL_W-1:0] w_dwell_m1;
    logic               w_loop_in;
    logic [APR-1:0]     w_fwd_nxt;
    logic [APR-1:0]     w_rev_nxt;
    logic               w_fwd_end;
    logic               w_rev_end;

    // Step toward a target without wrapping; any overshoot (including carry/borrow) clamps to the target.
    function automatic logic [APR-1:0] step_toward(
        input logic [APR-1:0] cur,
        input logic [APR-1:0] stp,
        input logic [APR-1:0] tgt,
        input logic           up
    );
        logic [APR:0] sum;
        logic [APR:0] diff;
        logic [APR-1:0] res;
        sum  = {1'b0, cur} + {1'b0, stp};
        diff = {1'b0, cur} - {1'b0, stp};
        if (up) begin
            res = (sum >= {1'b0, tgt}) ? tgt : sum[APR-1:0];
        end else begin
            res = (diff[APR] || (diff[APR-1:0] <= tgt)) ? tgt : diff[APR-1:0];
        end
        return res;
    endfunction

    // A dwell of zero behaves as one cycle, so the counter reload is max(dwell,1)-1.
    assign w_dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

`ifdef NCO_SWEEP_LOOP_EN
    assign w_loop_in = loop_en;
`else
    assign w_loop_in = 1'b0;
`endif

    // Next values for each leg: forward heads to f_stop, reverse mirrors back to f_start.
    always_comb begin
        w_fwd_nxt = step_toward(r_phi, r_step, r_stop, r_dir_up);
        w_rev_nxt = step_toward(r_phi, r_step, r_start, ~r_dir_up);
        w_fwd_end = r_degen || (r_phi == r_stop);
        w_rev_end = (r_phi == r_start);
    end

    // Sweep FSM with registered outputs; stop aborts from any active state without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_start    <= '0;
            r_stop     <= '0;
            r_step     <= '0;
            r_dwell_m1 <= '0;
            r_tri      <= 1'b0;
            r_dir_up   <= 1'b0;
            r_degen    <= 1'b0;
            r_loop     <= 1'b0;
            r_cnt      <= '0;
            r_phi      <= '0;
            r_upd      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_upd  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_start    <= f_start;
                        r_stop     <= f_stop;
                        r_step     <= f_step;
                        r_dwell_m1 <= w_dwell_m1;
                        r_tri      <= tri_mode;
                        r_dir_up   <= (f_stop >= f_start);
                        r_degen    <= (f_step == '0) || (f_start == f_stop);
                        r_loop     <= w_loop_in;
                        r_cnt      <= w_dwell_m1;
                        r_phi      <= f_start;
                        r_upd      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN_FWD;
                    end
                end
                S_RUN_FWD: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end else if (w_fwd_end) begin
                        if (r_tri && !r_degen) begin
                            // Turnaround: f_stop is not repeated, the first reverse value follows directly.
                            r_phi   <= w_rev_nxt;
                            r_upd   <= 1'b1;
                            r_cnt   <= r_dwell_m1;
                            r_state <= S_RUN_REV;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end else begin
                        r_phi <= w_fwd_nxt;
                        r_upd <= 1'b1;
                        r_cnt <= r_dwell_m1;
                    end
                end
                S_RUN_REV: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end else if (w_rev_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_phi <= w_rev_nxt;
                        r_upd <= 1'b1;
                        r_cnt <= r_dwell_m1;
                    end
                end
                S_FINISH: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_loop) begin
                        r_phi   <= r_start;
                        r_upd   <= 1'b1;
                        r_cnt   <= r_dwell_m1;
                        r_state <= S_RUN_FWD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign phi_inc_o  = r_phi;
    assign freq_upd   = r_upd;
    assign busy       = r_busy;
    assign sweep_done = r_done;

endmodule
